// File: rtl/clk_div_monitor.sv
// clk_div_monitor: checks two divided clocks generated in the clk domain.
// Both inputs are edge-detected and timed in clk cycles. Each measured period,
// high time and the relative phase of the two clocks is compared against the
// expected values. The block reports lock, a one-cycle error strike, sticky
// error causes and the last measured periods.
// Optional feature: define CLK_MON_DUTY_CHECK_EN to build the high-time
// counters and enable the duty check (err_flags[2]). Without it, err_flags[2]
// is tied to 0.
module clk_div_monitor #(
  parameter int EXP_PERIOD_A = 4,
  parameter int EXP_HIGH_A   = 2,
  parameter int EXP_PERIOD_B = 12,
  parameter int EXP_HIGH_B   = 6,
  parameter int LOCK_COUNT   = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_a_in,
  input  logic             clk_b_in,
  input  logic             clear_err,
  output logic             a_rise,
  output logic             b_rise,
  output logic [CNT_W-1:0] period_a,
  output logic [CNT_W-1:0] period_b,
  output logic             lock,
  output logic             err,
  output logic [4:0]       err_flags
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_PA    = CNT_W'(EXP_PERIOD_A);
  localparam logic [CNT_W-1:0] EXP_PB    = CNT_W'(EXP_PERIOD_B);
  // Timeout is flagged on the edge where the counter would reach 2*period.
  localparam logic [CNT_W-1:0] TO_A      = CNT_W'(2 * EXP_PERIOD_A - 1);
  localparam logic [CNT_W-1:0] TO_B      = CNT_W'(2 * EXP_PERIOD_B - 1);
  localparam logic [CNT_W-1:0] PH_LAST   = CNT_W'(EXP_PERIOD_B / EXP_PERIOD_A - 1);
  localparam logic [GW-1:0]    GOOD_ONE  = GW'(1);
  localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [GW-1:0]    GOOD_FULL = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;

  // Saturating increment shared by all counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  logic             s_a_p0, s_b_p0;
  logic             d_a_p1, d_b_p1;
  logic             rise_a, rise_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             armed_a, armed_b;
  logic [CNT_W-1:0] ph_cnt;
  logic             to_a, to_b, timeout;
  logic             per_err_a, per_err_b, duty_err, ph_err;
  logic [4:0]       causes;
  logic             any_err;
  logic             err_since;
  logic [GW-1:0]    good_cnt;
  state_t           state;

  // Stage p0: sample register, stage p1: delay register for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s_a_p0 <= 1'b0;
      s_b_p0 <= 1'b0;
      d_a_p1 <= 1'b0;
      d_b_p1 <= 1'b0;
    end else begin
      s_a_p0 <= clk_a_in;
      s_b_p0 <= clk_b_in;
      d_a_p1 <= s_a_p0;
      d_b_p1 <= s_b_p0;
    end
  end

  assign rise_a = s_a_p0 & ~d_a_p1;
  assign rise_b = s_b_p0 & ~d_b_p1;

  // A channel that is armed and stays quiet for 2*period has stalled.
  assign to_a    = armed_a & ~rise_a & (cnt_a == TO_A);
  assign to_b    = armed_b & ~rise_b & (cnt_b == TO_B);
  assign timeout = to_a | to_b;

  assign per_err_a = rise_a & armed_a & (cnt_a != EXP_PA);
  assign per_err_b = rise_b & armed_b & (cnt_b != EXP_PB);

  // B must rise together with A, and A may not complete a full B period alone.
  assign ph_err = armed_a & armed_b &
                  ((rise_b & ~rise_a) | (rise_a & ~rise_b & (ph_cnt == PH_LAST)));

`ifdef CLK_MON_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] EXP_HA = CNT_W'(EXP_HIGH_A);
  localparam logic [CNT_W-1:0] EXP_HB = CNT_W'(EXP_HIGH_B);

  logic             fall_a, fall_b;
  logic [CNT_W-1:0] hi_cnt_a, hi_cnt_b;
  logic [CNT_W-1:0] hi_a, hi_b;

  assign fall_a = ~s_a_p0 & d_a_p1;
  assign fall_b = ~s_b_p0 & d_b_p1;

  // High-time counters: count while high, capture and clear on the fall
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_cnt_a <= '0;
      hi_cnt_b <= '0;
      hi_a     <= '0;
      hi_b     <= '0;
    end else begin
      if (s_a_p0) begin
        hi_cnt_a <= sat_inc(hi_cnt_a);
      end else if (fall_a) begin
        hi_a     <= hi_cnt_a;
        hi_cnt_a <= '0;
      end
      if (s_b_p0) begin
        hi_cnt_b <= sat_inc(hi_cnt_b);
      end else if (fall_b) begin
        hi_b     <= hi_cnt_b;
        hi_cnt_b <= '0;
      end
    end
  end

  assign duty_err = (rise_a & armed_a & (hi_a != EXP_HA)) |
                    (rise_b & armed_b & (hi_b != EXP_HB));
`else
  assign duty_err = 1'b0;
`endif

  assign causes  = {timeout, ph_err, duty_err, per_err_b, per_err_a};
  assign any_err = |causes;

  // Stage p2: period counters, captured periods, rise pulses and arming
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a    <= '0;
      cnt_b    <= '0;
      period_a <= '0;
      period_b <= '0;
      a_rise   <= 1'b0;
      b_rise   <= 1'b0;
      armed_a  <= 1'b0;
      armed_b  <= 1'b0;
    end else begin
      a_rise <= rise_a;
      b_rise <= rise_b;
      if (rise_a) begin
        period_a <= cnt_a;
        cnt_a    <= ONE;
        armed_a  <= 1'b1;
      end else begin
        cnt_a <= sat_inc(cnt_a);
        if (to_a) armed_a <= 1'b0;
      end
      if (rise_b) begin
        period_b <= cnt_b;
        cnt_b    <= ONE;
        armed_b  <= 1'b1;
      end else begin
        cnt_b <= sat_inc(cnt_b);
        if (to_b) armed_b <= 1'b0;
      end
    end
  end

  // Counts A rises since the last B rise to catch a missing B edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_cnt <= '0;
    end else if (rise_b) begin
      ph_cnt <= '0;
    end else if (rise_a) begin
      ph_cnt <= (ph_cnt == PH_LAST) ? '0 : ph_cnt + ONE;
    end
  end

  // Error strike and sticky causes; a new cause wins over clear_err
  always_ff @(posedge clk) begin
    if (reset) begin
      err       <= 1'b0;
      err_flags <= '0;
    end else begin
      err       <= any_err;
      err_flags <= (clear_err ? 5'b0 : err_flags) | causes;
    end
  end

  // Lock FSM: acquire arming, track good B periods, hold lock until a fault
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACQUIRE;
      good_cnt  <= '0;
      err_since <= 1'b0;
      lock      <= 1'b0;
    end else begin
      err_since <= rise_b ? 1'b0 : (err_since | any_err);
      case (state)
        ACQUIRE: begin
          lock     <= 1'b0;
          good_cnt <= '0;
          if (armed_a && armed_b && !timeout) state <= TRACK;
        end
        TRACK, LOCKED: begin
          if (timeout) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
            lock     <= 1'b0;
          end else if (any_err) begin
            state    <= TRACK;
            good_cnt <= '0;
            lock     <= 1'b0;
          end else if (state == TRACK && rise_b && !err_since) begin
            if (good_cnt == GOOD_LAST) begin
              state    <= LOCKED;
              good_cnt <= GOOD_FULL;
              lock     <= 1'b1;
            end else begin
              good_cnt <= good_cnt + GOOD_ONE;
            end
          end
        end
        default: begin
          state    <= ACQUIRE;
          good_cnt <= '0;
          lock     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor with default parameters. A divider model
// drives the two inputs from a position counter; stimulus variants (A stretch,
// B hold-low, B phase shift, B duty skew) are applied at fixed positions and
// every expected value is worked out by hand from the cycle timeline.
module tb_clk_div_monitor;

`ifdef CLK_MON_DUTY_CHECK_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       clk_a_in;
  logic       clk_b_in;
  logic       clear_err;
  logic       a_rise;
  logic       b_rise;
  logic [7:0] period_a;
  logic [7:0] period_b;
  logic       lock;
  logic       err;
  logic [4:0] err_flags;

  int n_checks = 0;
  int n_fail   = 0;

  // Divider model state
  int pos     = 0;
  int stretch = -100;  // A rise position whose period is stretched to 5 then 3
  int b_off   = 0;     // B rise offset in clk cycles
  int b_hi    = 6;     // B high time
  bit b_hold  = 1'b0;
  bit quiet   = 1'b1;

  clk_div_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .clk_a_in  (clk_a_in),
    .clk_b_in  (clk_b_in),
    .clear_err (clear_err),
    .a_rise    (a_rise),
    .b_rise    (b_rise),
    .period_a  (period_a),
    .period_b  (period_b),
    .lock      (lock),
    .err       (err),
    .err_flags (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the inputs for the current position, then advance one clock.
  task automatic norm(input int n);
    for (int i = 0; i < n; i++) begin
      logic a, b;
      a = ((pos % 4) < 2);
      if (pos == stretch + 4) a = 1'b0;
      if (pos == stretch + 6) a = 1'b1;
      b = (((pos + 12 - b_off) % 12) < b_hi);
      if (quiet) a = 1'b0;
      if (quiet || b_hold) b = 1'b0;
      clk_a_in = a;
      clk_b_in = b;
      pos++;
      tick();
    end
  endtask

  initial begin
    reset     = 1'b1;
    clear_err = 1'b0;
    clk_a_in  = 1'b0;
    clk_b_in  = 1'b0;
    repeat (3) tick();

    check("reset a_rise", a_rise, 1'b0);
    check("reset b_rise", b_rise, 1'b0);
    check("reset period_a", period_a, 8'd0);
    check("reset period_b", period_b, 8'd0);
    check("reset lock", lock, 1'b0);
    check("reset err", err, 1'b0);
    check("reset err_flags", err_flags, 5'd0);

    // Release reset; position 0 (both rise) is driven on this tick (t0).
    reset = 1'b0;
    quiet = 1'b0;
    norm(2);   // t0+2
    check("arm a_rise", a_rise, 1'b1);
    check("arm b_rise", b_rise, 1'b1);
    check("arm err", err, 1'b0);
    norm(1);   // t0+3
    check("a_rise one cycle", a_rise, 1'b0);
    norm(46);  // t0+49
    check("pre-lock lock", lock, 1'b0);
    check("period_a nominal", period_a, 8'd4);
    check("period_b nominal", period_b, 8'd12);
    check("nominal err_flags", err_flags, 5'd0);
    norm(1);   // t0+50
    check("lock asserted", lock, 1'b1);
    check("lock with b_rise", b_rise, 1'b1);

    // A periods 5 then 3 around position 52.
    stretch = 52;
    norm(9);   // t0+59
    check("stretch err", err, 1'b1);
    check("stretch period_a", period_a, 8'd5);
    check("stretch err_flags", err_flags, 5'b00001);
    check("stretch lock drop", lock, 1'b0);
    norm(1);   // t0+60
    check("err one cycle", err, 1'b0);
    norm(2);   // t0+62
    check("short err", err, 1'b1);
    check("short period_a", period_a, 8'd3);
    check("short b_rise", b_rise, 1'b1);
    norm(47);  // t0+109
    check("relock pending", lock, 1'b0);
    norm(1);   // t0+110
    check("relock", lock, 1'b1);

    clear_err = 1'b1;
    norm(1);   // t0+111
    clear_err = 1'b0;
    check("clear err_flags", err_flags, 5'd0);

    // Second stretch; clear_err coincides with the second period fault.
    stretch = 124;
    norm(20);  // t0+131
    check("stretch2 err", err, 1'b1);
    check("stretch2 err_flags", err_flags, 5'b00001);
    check("stretch2 lock drop", lock, 1'b0);
    norm(2);   // t0+133
    clear_err = 1'b1;
    norm(1);   // t0+134
    clear_err = 1'b0;
    check("clear vs fault err", err, 1'b1);
    check("clear vs fault flags", err_flags, 5'b00001);
    norm(1);   // t0+135
    check("flags sticky", err_flags, 5'b00001);
    clear_err = 1'b1;
    norm(1);   // t0+136
    clear_err = 1'b0;
    check("clear again", err_flags, 5'd0);
    norm(46);  // t0+182
    check("lock before stall", lock, 1'b1);

    // Hold B low after the rise at position 180.
    norm(6);   // t0+188
    b_hold = 1'b1;
    norm(6);   // t0+194
    check("missing B phase err", err, 1'b1);
    check("missing B flags", err_flags, 5'b01000);
    check("missing B lock", lock, 1'b0);
    norm(10);  // t0+204
    check("pre-timeout err", err, 1'b0);
    check("pre-timeout flags", err_flags, 5'b01000);
    norm(1);   // t0+205
    check("timeout err", err, 1'b1);
    check("timeout flags", err_flags, 5'b11000);
    check("timeout lock", lock, 1'b0);
    norm(1);   // t0+206
    check("timeout once", err, 1'b0);
    check("no phase when disarmed", err_flags, 5'b11000);
    norm(10);  // t0+216
    b_hold = 1'b0;
    norm(49);  // t0+265
    check("rearm lock pending", lock, 1'b0);
    norm(1);   // t0+266
    check("rearm lock", lock, 1'b1);
    check("rearm period_b", period_b, 8'd12);

    clear_err = 1'b1;
    norm(1);   // t0+267
    clear_err = 1'b0;
    check("clear before shift", err_flags, 5'd0);

    // B shifted one cycle late from position 276 onward.
    norm(9);   // t0+276
    b_off = 1;
    norm(2);   // t0+278
    check("shift A-only err", err, 1'b1);
    check("shift A-only flags", err_flags, 5'b01000);
    norm(1);   // t0+279
    check("shift B err", err, 1'b1);
    check("shift B flags", err_flags, 5'b01010);
    check("shift period_b", period_b, 8'd13);
    clear_err = 1'b1;
    norm(1);   // t0+280
    clear_err = 1'b0;
    check("shift clear", err_flags, 5'd0);
    norm(10);  // t0+290
    check("shift A-only err 2", err, 1'b1);
    norm(1);   // t0+291
    check("shift B err 2", err, 1'b1);
    check("shift B rise 2", b_rise, 1'b1);
    check("shift B flags 2", err_flags, 5'b01000);
    norm(60);  // t0+351
    check("shift never locks", lock, 1'b0);

    // Reset mid-TRACK.
    reset = 1'b1;
    quiet = 1'b1;
    norm(1);   // t0+352
    check("midreset a_rise", a_rise, 1'b0);
    check("midreset b_rise", b_rise, 1'b0);
    check("midreset period_a", period_a, 8'd0);
    check("midreset period_b", period_b, 8'd0);
    check("midreset lock", lock, 1'b0);
    check("midreset err", err, 1'b0);
    check("midreset err_flags", err_flags, 5'd0);
    norm(8);   // t0+360

    // B duty 7/5 with correct period and phase.
    reset = 1'b0;
    quiet = 1'b0;
    b_off = 0;
    b_hi  = 7;
    norm(14);  // t0+374
    check("duty period_b", period_b, 8'd12);
    check("duty err", err, DUTY_EN);
    check("duty err_flags", err_flags, DUTY_EN ? 5'b00100 : 5'b00000);
    norm(35);  // t0+409
    check("duty lock pending", lock, 1'b0);
    norm(1);   // t0+410
    check("duty lock", lock, !DUTY_EN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
